disp_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 12 +
 rtl/disp_lz_mask.sv | 25 ++
 rtl/disp_scan.sv | 105 ++++++++++
 tb/tb_disp_scan.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit display scan driver.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } state_t;

endpackage

// File: rtl/disp_lz_mask.sv
// Leading-zero suppression mask derived from the latched frame value.
// Digit 0 is never suppressed so an all-zero value still shows a single 0.
module disp_lz_mask
  import disp_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] i_sh_data,
  input  logic                    i_sh_lz,
  output logic [NUM_DIGITS-1:0]   o_sup
);

  logic w_z3;
  logic w_z2;
  logic w_z1;

  assign w_z3 = (i_sh_data[15:12] == 4'h0);
  assign w_z2 = (i_sh_data[11:8]  == 4'h0);
  assign w_z1 = (i_sh_data[7:4]   == 4'h0);

  // A digit is suppressed only while every more-significant nibble is zero too.
  assign o_sup[3] = i_sh_lz & w_z3;
  assign o_sup[2] = o_sup[3] & w_z2;
  assign o_sup[1] = o_sup[2] & w_z1;
  assign o_sup[0] = 1'b0;

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed scan driver for a 4-digit 7-segment display.
// A frame value is latched at the digit-0 BLANK exit, then the four digits are
// walked with an all-anodes-off gap between them to suppress ghosting.
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  input  logic        hold,
  output logic [3:0]  hex,
  output logic        point,
  output logic        le,
  output logic [3:0]  an,
  output logic        frame_start
);

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_sh_data;
  logic [3:0]         r_sh_dp;
  logic [3:0]         r_sh_en;
  logic               r_sh_lz;
  logic               r_frame_start;

  logic [3:0]         w_sup;
  logic [3:0]         w_nib;
  logic [3:0]         w_an_on;
  logic               w_blank_end;
  logic               w_disp_end;

  assign w_blank_end = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
  assign w_disp_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));

  // Scan FSM, cycle counter, digit index and frame shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BLANK;
      r_idx         <= 2'd0;
      r_cnt         <= '0;
      r_sh_data     <= 16'h0000;
      r_sh_dp       <= 4'h0;
      r_sh_en       <= 4'h0;
      r_sh_lz       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_BLANK: begin
          if (w_blank_end) begin
            r_state <= ST_DISPLAY;
            r_cnt   <= '0;
            if ((r_idx == 2'd0) && !hold) begin
              r_sh_data     <= data;
              r_sh_dp       <= dp;
              r_sh_en       <= digit_en;
              r_sh_lz       <= lz_en;
              r_frame_start <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DISPLAY: begin
          if (w_disp_end) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= r_idx + 2'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  disp_lz_mask u_lz_mask (
    .i_sh_data (r_sh_data),
    .i_sh_lz   (r_sh_lz),
    .o_sup     (w_sup)
  );

  // Output decode works purely from registered state.
  assign w_nib   = 4'(r_sh_data >> {r_idx, 2'b00});
  assign w_an_on = ~(4'(r_sh_en[r_idx]) << r_idx);

  assign hex         = w_nib;
  assign an          = (r_state == ST_DISPLAY) ? w_an_on : AN_OFF;
  assign le          = (r_state == ST_DISPLAY) ? w_sup[r_idx] : 1'b1;
  assign point       = (r_state == ST_DISPLAY) ? (r_sh_dp[r_idx] & ~w_sup[r_idx]) : 1'b0;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with a short scan (8 lit + 2 blank cycles).
module tb_disp_scan;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned BLANK_CYCLES = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int          DIG_PER      = 10;
  localparam int          FRAME        = 40;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        lz_en;
  logic        hold;
  logic [3:0]  hex;
  logic        point;
  logic        le;
  logic [3:0]  an;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  disp_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .dp          (dp),
    .digit_en    (digit_en),
    .lz_en       (lz_en),
    .hold        (hold),
    .hex         (hex),
    .point       (point),
    .le          (le),
    .an          (an),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_an, input logic [3:0] e_hex,
                         input logic e_le, input logic e_pt, input logic e_fs);
    chk({tag, " an"},    16'(an),          16'(e_an));
    chk({tag, " hex"},   16'(hex),         16'(e_hex));
    chk({tag, " le"},    16'(le),          16'(e_le));
    chk({tag, " point"}, 16'(point),       16'(e_pt));
    chk({tag, " fs"},    16'(frame_start), 16'(e_fs));
  endtask

  // Walks one full frame starting at the negedge just after the load edge.
  // e_an/e_hex are packed digit3..digit0; chg_t >= 0 rewrites data at that step.
  task automatic check_frame(input string name, input logic [15:0] e_an, input logic [15:0] e_hex,
                             input logic [3:0] e_le, input logic [3:0] e_pt, input logic e_fs,
                             input int chg_t, input logic [15:0] chg_val);
    int k;
    int ph;
    logic [3:0] x_an;
    logic [3:0] x_hex;
    logic x_le;
    logic x_pt;
    logic x_fs;
    for (int t = 0; t < FRAME; t++) begin
      if (t > 0) @(negedge clk);
      k  = t / DIG_PER;
      ph = t % DIG_PER;
      if (ph < int'(SCAN_DIV)) begin
        x_an  = e_an[k*4 +: 4];
        x_hex = e_hex[k*4 +: 4];
        x_le  = e_le[k];
        x_pt  = e_pt[k];
      end else begin
        x_an  = 4'b1111;
        x_hex = e_hex[((k + 1) % 4)*4 +: 4];
        x_le  = 1'b1;
        x_pt  = 1'b0;
      end
      x_fs = (t == 0) ? e_fs : 1'b0;
      chk_all($sformatf("%s t=%0d", name, t), x_an, x_hex, x_le, x_pt, x_fs);
      if (t == chg_t) data = chg_val;
    end
  endtask

  localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial begin
    rst      = 1'b1;
    data     = 16'h1A2F;
    dp       = 4'b0000;
    digit_en = 4'b1111;
    lz_en    = 1'b0;
    hold     = 1'b0;

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    chk_all("reset", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_all("post_rst1", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Plain hex, two consecutive frames.
    check_frame("f1_1A2F", AN_ALL, 16'h1A2F, 4'b0000, 4'b0000, 1'b1, -1, 16'h0);
    @(negedge clk);
    check_frame("f2_1A2F", AN_ALL, 16'h1A2F, 4'b0000, 4'b0000, 1'b1, -1, 16'h0);

    // Leading-zero suppression.
    data  = 16'h0070;
    lz_en = 1'b1;
    @(negedge clk);
    check_frame("f3_0070lz", AN_ALL, 16'h0070, 4'b1100, 4'b0000, 1'b1, -1, 16'h0);
    data = 16'h0000;
    @(negedge clk);
    check_frame("f4_0000lz", AN_ALL, 16'h0000, 4'b1110, 4'b0000, 1'b1, -1, 16'h0);

    // Decimal point on a disabled digit.
    data     = 16'h1234;
    lz_en    = 1'b0;
    dp       = 4'b0100;
    digit_en = 4'b1011;
    @(negedge clk);
    check_frame("f5_dp_en", {4'b0111, 4'b1111, 4'b1101, 4'b1110}, 16'h1234,
                4'b0000, 4'b0100, 1'b1, -1, 16'h0);

    // Data change during digit 2's window must not tear the frame.
    dp       = 4'b0000;
    digit_en = 4'b1111;
    @(negedge clk);
    check_frame("f6_notear", AN_ALL, 16'h1234, 4'b0000, 4'b0000, 1'b1, 22, 16'h5678);
    @(negedge clk);
    check_frame("f7_5678", AN_ALL, 16'h5678, 4'b0000, 4'b0000, 1'b1, -1, 16'h0);

    // Hold across two frame boundaries, then release.
    hold = 1'b1;
    data = 16'h9ABC;
    @(negedge clk);
    check_frame("f8_hold", AN_ALL, 16'h5678, 4'b0000, 4'b0000, 1'b0, -1, 16'h0);
    @(negedge clk);
    check_frame("f9_hold", AN_ALL, 16'h5678, 4'b0000, 4'b0000, 1'b0, -1, 16'h0);
    hold = 1'b0;
    @(negedge clk);
    check_frame("f10_9ABC", AN_ALL, 16'h9ABC, 4'b0000, 4'b0000, 1'b1, -1, 16'h0);

    // Reset mid-digit discards shadows and restarts the sequence.
    repeat (14) @(negedge clk);
    chk_all("mid_digit1", 4'b1101, 4'hB, 1'b0, 1'b0, 1'b0);
    rst  = 1'b1;
    data = 16'hBEEF;
    @(negedge clk);
    chk_all("mid_reset", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_all("mid_post1", 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk_all("mid_load", 4'b1110, 4'hF, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
